// File: rtl/display_buffer.sv
// Calculator display line buffer. Collects keypad symbols into a packed
// vector for the VGA text renderer. Handles backspace and clear. After '='
// the next operand key wipes the line one slot per cycle and then starts a
// new entry with that key.
module display_buffer #(
  parameter int unsigned maxInput = 60
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [3:0]          in_code,
  output logic [maxInput-1:0] numbers,
  output logic [4:0]          count,
  output logic                full,
  output logic                empty,
  output logic                overflow
);

  localparam int unsigned SLOTS   = maxInput / 4;
  localparam logic [4:0]  SlotsC  = 5'(SLOTS);
  localparam logic [4:0]  LastPtr = 5'(SLOTS - 1);

  localparam logic [1:0] OpAppend    = 2'b00;
  localparam logic [1:0] OpBackspace = 2'b01;
  localparam logic [1:0] OpClear     = 2'b10;

  localparam logic [3:0] CodeEq    = 4'he;
  localparam logic [3:0] CodeBlank = 4'hf;

  typedef enum logic [1:0] {
    StEdit,
    StResult,
    StClearing
  } state_e;

  state_e                state_q, state_d;
  logic [maxInput-1:0]   numbers_q, numbers_d;
  logic [4:0]            count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic [4:0]            ptr_q, ptr_d;
  logic                  pend_q, pend_d;
  logic [3:0]            pcode_q, pcode_d;
  logic                  hs;

  assign in_ready = (state_q != StClearing);
  assign hs       = in_valid & in_ready;

  // Next-state: command decode in EDIT/RESULT, progressive wipe in CLEARING
  always_comb begin
    state_d   = state_q;
    numbers_d = numbers_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    ptr_d     = ptr_q;
    pend_d    = pend_q;
    pcode_d   = pcode_q;
    unique case (state_q)
      StEdit, StResult: begin
        if (hs) begin
          unique case (in_op)
            OpAppend: begin
              if (state_q == StEdit) begin
                if (count_q == SlotsC) begin
                  ovf_d = 1'b1;
                end else if (in_code != CodeBlank) begin
                  for (int unsigned k = 0; k < SLOTS; k++) begin
                    if (count_q == 5'(k)) numbers_d[4*k +: 4] = in_code;
                  end
                  count_d = count_q + 5'd1;
                  if (in_code == CodeEq) state_d = StResult;
                end
              end else if (in_code <= 4'hd) begin
                // Operand after a result: wipe the line, then start with this key
                pcode_d = in_code;
                pend_d  = 1'b1;
                ptr_d   = 5'd0;
                state_d = StClearing;
              end
            end
            OpBackspace: begin
              if (count_q != 5'd0) begin
                for (int unsigned k = 0; k < SLOTS; k++) begin
                  if (count_q == 5'(k + 1)) numbers_d[4*k +: 4] = CodeBlank;
                end
                count_d = count_q - 5'd1;
              end
              state_d = StEdit;
            end
            OpClear: begin
              ptr_d   = 5'd0;
              pend_d  = 1'b0;
              state_d = StClearing;
            end
            default: ;
          endcase
        end
      end
      StClearing: begin
        for (int unsigned k = 0; k < SLOTS; k++) begin
          if (ptr_q == 5'(k)) numbers_d[4*k +: 4] = CodeBlank;
        end
        ptr_d = ptr_q + 5'd1;
        if (ptr_q == LastPtr) begin
          ovf_d   = 1'b0;
          ptr_d   = 5'd0;
          state_d = StEdit;
          if (pend_q) begin
            numbers_d[3:0] = pcode_q;
            count_d        = 5'd1;
            pend_d         = 1'b0;
          end else begin
            count_d = 5'd0;
          end
        end
      end
      default: state_d = StEdit;
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StEdit;
      numbers_q <= '1;
      count_q   <= 5'd0;
      ovf_q     <= 1'b0;
      ptr_q     <= 5'd0;
      pend_q    <= 1'b0;
      pcode_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      numbers_q <= numbers_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      ptr_q     <= ptr_d;
      pend_q    <= pend_d;
      pcode_q   <= pcode_d;
    end
  end

  assign numbers  = numbers_q;
  assign count    = count_q;
  assign full     = (count_q == SlotsC);
  assign empty    = (count_q == 5'd0);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_display_buffer.sv
// Bench for display_buffer: a queue-based display model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_display_buffer;

  localparam int unsigned MaxIn = 60;
  localparam int          Slots = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b11;
  logic [3:0]       in_code = 4'h0;
  logic [MaxIn-1:0] numbers;
  logic [4:0]       count;
  logic             full, empty, overflow;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  display_buffer #(.maxInput(MaxIn)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_code  (in_code),
    .numbers  (numbers),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // Model: the line is a queue of symbols; mode 0 edit, 1 result, 2 clearing
  int  mq[$];
  bit  m_ovf;
  int  m_mode;
  int  m_wiped;
  bit  m_pend;
  int  m_pcode;
  bit  m_live = 1'b0;

  function automatic void apply(input logic [1:0] op, input logic [3:0] c);
    case (op)
      2'b00: begin
        if (m_mode == 0) begin
          if (mq.size() == Slots) m_ovf = 1'b1;
          else if (c != 4'hf) begin
            mq.push_back(int'(c));
            if (c == 4'he) m_mode = 1;
          end
        end else if (c <= 4'hd) begin
          m_pend = 1'b1; m_pcode = int'(c); m_mode = 2; m_wiped = 0;
        end
      end
      2'b01: begin
        if (mq.size() > 0) void'(mq.pop_back());
        m_mode = 0;
      end
      2'b10: begin
        m_mode = 2; m_wiped = 0; m_pend = 1'b0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [MaxIn-1:0] exp_numbers();
    logic [MaxIn-1:0] e;
    e = '1;
    for (int k = 0; k < Slots; k++) begin
      if (k < mq.size() && !(m_mode == 2 && k < m_wiped)) e[4*k +: 4] = 4'(mq[k]);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete(); m_ovf = 1'b0; m_mode = 0; m_wiped = 0; m_pend = 1'b0; m_pcode = 0;
    end else if (m_mode == 2) begin
      m_wiped++;
      if (m_wiped == Slots) begin
        mq.delete();
        if (m_pend) mq.push_back(m_pcode);
        m_pend = 1'b0; m_ovf = 1'b0; m_mode = 0;
      end
    end else if (in_valid) begin
      apply(in_op, in_code);
    end
    m_live = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_numbers", 64'(numbers), 64'(exp_numbers()));
      chk("m_count", 64'(count), 64'(mq.size()));
      chk("m_full", 64'(full), 64'(mq.size() == Slots));
      chk("m_empty", 64'(empty), 64'(mq.size() == 0));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      chk("m_in_ready", 64'(in_ready), 64'(m_mode != 2));
    end
  end

  task automatic cmd(input logic [1:0] op, input logic [3:0] c);
    in_valid = 1'b1; in_op = op; in_code = c;
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 2'b11; in_code = 4'h0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_numbers", 64'(numbers), 64'h0fff_ffff_ffff_ffff);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // 1 2 + 3
    cmd(2'b00, 4'h1); cmd(2'b00, 4'h2); cmd(2'b00, 4'ha); cmd(2'b00, 4'h3);
    chk("append_numbers", 64'(numbers), 64'h0fff_ffff_ffff_3a21);
    chk("append_count", 64'(count), 64'd4);

    // Sixteen 7s: fifteen fit, the last overflows
    do_reset();
    repeat (15) cmd(2'b00, 4'h7);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_ovf_before", 64'(overflow), 64'd0);
    cmd(2'b00, 4'h7);
    chk("fill_numbers", 64'(numbers), 64'h0777_7777_7777_7777);
    chk("fill_count", 64'(count), 64'd15);
    chk("fill_ovf", 64'(overflow), 64'd1);
    cmd(2'b10, 4'h0);
    wait_ready(n);
    chk("clear_cycles", 64'(n), 64'd15);
    chk("clear_numbers", 64'(numbers), 64'h0fff_ffff_ffff_ffff);
    chk("clear_count", 64'(count), 64'd0);
    chk("clear_ovf", 64'(overflow), 64'd0);

    // 5 + 5 = then 9 starts a new line
    cmd(2'b00, 4'h5); cmd(2'b00, 4'ha); cmd(2'b00, 4'h5); cmd(2'b00, 4'he);
    chk("eq_numbers", 64'(numbers), 64'h0fff_ffff_ffff_e5a5);
    cmd(2'b00, 4'he); cmd(2'b00, 4'hf);
    chk("result_ignore_count", 64'(count), 64'd4);
    chk("result_ignore_ready", 64'(in_ready), 64'd1);
    cmd(2'b00, 4'h9);
    wait_ready(n);
    chk("result_cycles", 64'(n), 64'd15);
    chk("result_numbers", 64'(numbers), 64'h0fff_ffff_ffff_fff9);
    chk("result_count", 64'(count), 64'd1);

    // Backspace on empty, then 4 2 backspace
    cmd(2'b10, 4'h0);
    wait_ready(n);
    cmd(2'b01, 4'h0);
    chk("bs_empty_count", 64'(count), 64'd0);
    chk("bs_empty_numbers", 64'(numbers), 64'h0fff_ffff_ffff_ffff);
    cmd(2'b00, 4'h4); cmd(2'b00, 4'h2); cmd(2'b01, 4'h0);
    chk("bs_numbers", 64'(numbers), 64'h0fff_ffff_ffff_fff4);
    chk("bs_count", 64'(count), 64'd1);

    // Reset on the 5th clearing cycle; in_valid pulses during clearing
    cmd(2'b00, 4'h8);
    cmd(2'b10, 4'h0);
    in_valid = 1'b1; in_op = 2'b00; in_code = 4'h3;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0; in_op = 2'b11;
    @(posedge clk); #1;
    chk("mid_clear_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ready", 64'(in_ready), 64'd1);
    chk("abort_numbers", 64'(numbers), 64'h0fff_ffff_ffff_ffff);
    chk("abort_count", 64'(count), 64'd0);
    cmd(2'b00, 4'h6);
    chk("after_abort_numbers", 64'(numbers), 64'h0fff_ffff_ffff_fff6);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
